// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the pipeline run controller.
//   state_t   : controller FSM state encoding (3 bits)
//   HALT_WORD : instruction encoding that ends a run
//   NOP_WORD  : encoding loaded into IF/ID when it is flushed
package cpu_run_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_DUMP_REQ = 3'd3,
      ST_DUMP_CAP = 3'd4,
      ST_DUMP_OUT = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/cpu_run_controller_sat_counter32.sv
// 32-bit saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to zero (wins over en)
//   en         : count enable; holds at all-ones once reached
//   count      : current value
module sat_counter32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the five-stage pipeline: releases fetch after start,
// freezes on the halt word, drains the pipeline, then streams main memory
// out over a valid/ready port.
//   start                      : begin a run (IDLE only)
//   if_instruction             : instruction fetched this cycle
//   pc_write_en/if_id_write_en : fetch enables (ANDed with hazard unit outside)
//   flush_if_id                : load NOP into IF/ID
//   cpu_run                    : high in RUN and DRAIN
//   mem_sel, dump_addr         : controller owns main-memory read address
//   mem_rdata                  : main-memory read data, 1-cycle latency
//   dump_valid/dump_data/dump_ready : dump stream handshake
//   done                       : dump complete, sticky until reset
//   cycle_count                : RUN + DRAIN cycles, saturating
module cpu_run_controller
   import cpu_run_controller_pkg::*;
#(
   parameter int          MEM_WORDS    = 512,
   parameter int          ADDR_W       = 9,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] HALT_WORD    = cpu_run_controller_pkg::HALT_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       if_instruction,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              flush_if_id,
   output logic              cpu_run,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] dump_addr,
   input  logic [31:0]       mem_rdata,
   output logic              dump_valid,
   output logic [31:0]       dump_data,
   input  logic              dump_ready,
   output logic              done,
   output logic [31:0]       cycle_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t             state_q, state_d;
   logic [DRAIN_W-1:0] drain_q;
   logic               halt_seen;
   logic               last_word;
   logic               run_start;

   assign halt_seen = (if_instruction == HALT_WORD);
   assign last_word = (dump_addr == ADDR_W'(MEM_WORDS - 1));
   assign run_start = (state_q == ST_IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      flush_if_id    = 1'b0;
      cpu_run        = 1'b0;
      mem_sel        = 1'b0;
      dump_valid     = 1'b0;
      done           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            cpu_run = 1'b1;
            // Combinational gating: the halt word itself never advances the PC.
            pc_write_en    = !halt_seen;
            if_id_write_en = !halt_seen;
            if (halt_seen) begin
               flush_if_id = 1'b1;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            cpu_run     = 1'b1;
            flush_if_id = 1'b1;
            if (drain_q == '0) state_d = ST_DUMP_REQ;
         end
         ST_DUMP_REQ: begin
            mem_sel = 1'b1;
            state_d = ST_DUMP_CAP;
         end
         ST_DUMP_CAP: begin
            mem_sel = 1'b1;
            state_d = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            mem_sel    = 1'b1;
            dump_valid = 1'b1;
            if (dump_ready) state_d = last_word ? ST_DONE : ST_DUMP_REQ;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Drain counter is loaded on the halt cycle so DRAIN lasts exactly
   // DRAIN_CYCLES cycles, counting down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_q <= '0;
      end else if (run_start) begin
         drain_q <= '0;
      end else if ((state_q == ST_RUN) && halt_seen) begin
         drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
         drain_q <= drain_q - DRAIN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dump_addr <= '0;
      end else if ((state_q == ST_DRAIN) && (drain_q == '0)) begin
         dump_addr <= '0;
      end else if ((state_q == ST_DUMP_OUT) && dump_ready && !last_word) begin
         dump_addr <= dump_addr + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dump_data <= '0;
      end else if (state_q == ST_DUMP_CAP) begin
         dump_data <= mem_rdata;
      end
   end

   sat_counter32 u_cycle_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (run_start),
      .en    ((state_q == ST_RUN) || (state_q == ST_DRAIN)),
      .count (cycle_count)
   );

endmodule
